// File: rtl/display_arbiter_pkg.sv
// Shared types and helpers for the 7-segment display arbiter: FSM states,
// requester indices and the round-robin pick function.
package display_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int REQ_ACCESS = 0;
  localparam int REQ_GAME   = 1;
  localparam int REQ_SCORE  = 2;
  localparam int NUM_REQ    = 3;

  // First set request searching upward from last_owner+1, wrapping modulo 3.
  function automatic logic [2:0] rr_pick(input logic [2:0] req,
                                         input logic [1:0] last_owner);
    logic [2:0] pick;
    pick = 3'b000;
    case (last_owner)
      2'd0: begin
        if      (req[REQ_GAME])   pick = 3'b010;
        else if (req[REQ_SCORE])  pick = 3'b100;
        else if (req[REQ_ACCESS]) pick = 3'b001;
      end
      2'd1: begin
        if      (req[REQ_SCORE])  pick = 3'b100;
        else if (req[REQ_ACCESS]) pick = 3'b001;
        else if (req[REQ_GAME])   pick = 3'b010;
      end
      default: begin
        if      (req[REQ_ACCESS]) pick = 3'b001;
        else if (req[REQ_GAME])   pick = 3'b010;
        else if (req[REQ_SCORE])  pick = 3'b100;
      end
    endcase
    return pick;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
    logic [1:0] idx;
    if      (oh[REQ_SCORE]) idx = 2'(REQ_SCORE);
    else if (oh[REQ_GAME])  idx = 2'(REQ_GAME);
    else                    idx = 2'(REQ_ACCESS);
    return idx;
  endfunction

endpackage

// File: rtl/display_arbiter_rr_picker.sv
// Combinational 3-way round-robin selector used by the display arbiter
// when it is idle and looking for the next owner.
module rr_picker
  import display_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last_owner,
  output logic [2:0] pick,
  output logic       valid
);

  assign pick  = rr_pick(req, last_owner);
  assign valid = |req;

endmodule

// File: rtl/display_arbiter.sv
// Arbitrates three requesters (access control, game, scoreboard) for one
// 7-segment display word, with a minimum hold, a starvation release and a gap.
module display_arbiter
  import display_arbiter_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int HOLD_CYCLES = 16,
  parameter int MAX_HOLD    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req,
  input  logic [3*DATA_W-1:0]   req_data,
  output logic [2:0]            gnt,
  output logic [DATA_W-1:0]     disp_data,
  output logic                  disp_valid,
  output logic                  busy
);

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] MAX_LIM  = 8'(MAX_HOLD - 1);

  state_t             state;
  logic [7:0]         hold_cnt;
  logic [1:0]         last_owner;
  logic [1:0]         owner;
  logic [2:0]         pick;
  logic               pick_vld;
  logic [DATA_W-1:0]  words [NUM_REQ];
  logic               hold_done;
  logic               starve;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign words[i] = req_data[i*DATA_W +: DATA_W];
  end

  rr_picker u_picker (
    .req        (req),
    .last_owner (last_owner),
    .pick       (pick),
    .valid      (pick_vld)
  );

  assign hold_done = !req[owner] && (hold_cnt >= HOLD_LIM);
  // >= rather than == so a saturated counter still releases to a late waiter.
  assign starve    = (|(req & ~gnt)) && (hold_cnt >= MAX_LIM);

  assign disp_valid = |gnt;
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      gnt        <= 3'b000;
      disp_data  <= '0;
      hold_cnt   <= 8'd0;
      last_owner <= 2'(REQ_SCORE);
      owner      <= 2'(REQ_ACCESS);
    end else begin
      case (state)
        ST_IDLE: begin
          disp_data <= '0;
          if (pick_vld) begin
            state    <= ST_OWN;
            gnt      <= pick;
            owner    <= onehot_idx(pick);
            hold_cnt <= 8'd0;
          end else begin
            gnt <= 3'b000;
          end
        end
        ST_OWN: begin
          if (hold_cnt != 8'hFF) hold_cnt <= hold_cnt + 8'd1;
          if (req[owner]) disp_data <= words[owner];
          if (hold_done || starve) begin
            state      <= ST_GAP;
            gnt        <= 3'b000;
            disp_data  <= '0;
            last_owner <= owner;
          end
        end
        ST_GAP: begin
          state     <= ST_IDLE;
          gnt       <= 3'b000;
          disp_data <= '0;
        end
        default: begin
          state     <= ST_IDLE;
          gnt       <= 3'b000;
          disp_data <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter: reset, latency, hold, round-robin,
// starvation release, mid-grant reset and a randomised invariant sweep.
module tb_display_arbiter;

  localparam int DW = 32;
  localparam int WAIT_BOUND = 2 * 255 + 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      req;
  logic [3*DW-1:0] req_data;
  logic [2:0]      gnt;
  logic [DW-1:0]   disp_data;
  logic            disp_valid;
  logic            busy;

  int checks = 0;
  int errors = 0;

  display_arbiter #(.DATA_W(DW), .HOLD_CYCLES(16), .MAX_HOLD(255)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 3'b000;
    step();
    step();
    rst = 1'b0;
  endtask

  // Steps until a grant appears; zeros counts the gnt==0 samples seen first.
  task automatic wait_for_gnt(output int zeros, output bit ok);
    zeros = 0;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (gnt !== 3'b000) begin
        ok = 1'b1;
        break;
      end
      zeros++;
      step();
    end
  endtask

  task automatic test_reset();
    req_data = '0;
    do_reset();
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b want 000", gnt); end
    checks++; if (disp_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", disp_data); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", disp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    step();
    checks++; if (gnt !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL idle_noreq got gnt=%b busy=%b want 000/0", gnt, busy); end
  endtask

  task automatic test_single_grant();
    int cnt;
    do_reset();
    req_data[DW +: DW] = 32'h1234;
    req = 3'b010;
    step();
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL single_gnt got %b want 010", gnt); end
    checks++; if (disp_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_flags got valid=%b busy=%b want 1/1", disp_valid, busy); end
    checks++; if (disp_data !== 32'h0) begin errors++; $display("FAIL single_lat1 got %h want 0", disp_data); end
    step();
    checks++; if (disp_data !== 32'h1234) begin errors++; $display("FAIL single_lat2 got %h want 1234", disp_data); end
    req_data[DW +: DW] = 32'h5678;
    step();
    checks++; if (disp_data !== 32'h5678) begin errors++; $display("FAIL single_track got %h want 5678", disp_data); end
    req = 3'b000;
    req_data[DW +: DW] = 32'hDEAD;
    step();
    cnt = 4;
    checks++; if (disp_data !== 32'h5678 || gnt !== 3'b010) begin errors++; $display("FAIL single_freeze got %h gnt=%b want 5678/010", disp_data, gnt); end
    for (int i = 0; i < 40; i++) begin
      step();
      if (gnt === 3'b010) cnt++;
      else break;
    end
    checks++; if (cnt != 16) begin errors++; $display("FAIL single_hold got %0d want 16", cnt); end
    checks++; if (gnt !== 3'b000 || disp_valid !== 1'b0 || disp_data !== 32'h0 || busy !== 1'b1) begin
      errors++; $display("FAIL gap_state got gnt=%b valid=%b data=%h busy=%b want 000/0/0/1", gnt, disp_valid, disp_data, busy);
    end
    step();
    checks++; if (busy !== 1'b0 || gnt !== 3'b000) begin errors++; $display("FAIL gap_to_idle got busy=%b gnt=%b want 0/000", busy, gnt); end
  endtask

  task automatic test_pulse_hold();
    int cnt;
    bit frozen_ok;
    do_reset();
    req_data[0 +: DW] = 32'hAAAA0001;
    req = 3'b001;
    step();
    req_data[0 +: DW] = 32'hAAAA0002;
    step();
    req_data[0 +: DW] = 32'hAAAA0003;
    step();
    req = 3'b000;
    req_data[0 +: DW] = 32'hAAAA0004;
    cnt = 3;
    checks++; if (disp_data !== 32'hAAAA0003) begin errors++; $display("FAIL pulse_last got %h want aaaa0003", disp_data); end
    frozen_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (gnt === 3'b001) begin
        cnt++;
        if (disp_data !== 32'hAAAA0003) frozen_ok = 1'b0;
      end else break;
    end
    checks++; if (cnt != 16) begin errors++; $display("FAIL pulse_hold got %0d want 16", cnt); end
    checks++; if (!frozen_ok) begin errors++; $display("FAIL pulse_frozen got changing data want aaaa0003"); end
    checks++; if (busy !== 1'b1 || gnt !== 3'b000) begin errors++; $display("FAIL pulse_gap got busy=%b gnt=%b want 1/000", busy, gnt); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_order [3];
    int zeros;
    bit ok, held;
    exp_order[0] = 3'b001; exp_order[1] = 3'b010; exp_order[2] = 3'b100;
    do_reset();
    req_data = {32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
    req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      wait_for_gnt(zeros, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rr_timeout owner %0d got none want grant", k); end
      checks++; if (gnt !== exp_order[k]) begin errors++; $display("FAIL rr_order[%0d] got %b want %b", k, gnt, exp_order[k]); end
      if (k > 0) begin
        checks++; if (zeros != 2) begin errors++; $display("FAIL rr_gap[%0d] got %0d want 2", k, zeros); end
      end
      held = 1'b1;
      for (int c = 1; c < 20; c++) begin
        step();
        if (gnt !== exp_order[k]) held = 1'b0;
        if (c == 1) begin
          checks++; if (disp_data !== (32'hC0DE0000 + 32'(k))) begin errors++; $display("FAIL rr_data[%0d] got %h want %h", k, disp_data, 32'hC0DE0000 + 32'(k)); end
        end
      end
      checks++; if (!held) begin errors++; $display("FAIL rr_held[%0d] got dropped grant want %b", k, exp_order[k]); end
      req = req & ~exp_order[k];
      step();
    end
  endtask

  task automatic test_starvation();
    int cnt, zeros;
    bit ok;
    do_reset();
    req_data = {32'h5C0E, 32'h6A3E, 32'hACCE};
    req = 3'b001;
    step();
    cnt = 1;
    for (int i = 0; i < 9; i++) begin
      step();
      if (gnt === 3'b001) cnt++;
    end
    req = 3'b101;
    for (int i = 0; i < 400; i++) begin
      step();
      if (gnt === 3'b001) cnt++;
      else break;
    end
    checks++; if (cnt != 255) begin errors++; $display("FAIL starve_release got %0d want 255", cnt); end
    wait_for_gnt(zeros, ok);
    checks++; if (!ok || zeros != 2) begin errors++; $display("FAIL starve_gap got %0d ok=%0d want 2", zeros, ok); end
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL starve_next got %b want 100", gnt); end
    req = 3'b000;
  endtask

  task automatic test_saturation();
    int waited;
    bit held;
    do_reset();
    req = 3'b001;
    step();
    held = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (gnt !== 3'b001) held = 1'b0;
    end
    checks++; if (!held) begin errors++; $display("FAIL sat_keep got lost grant want 001"); end
    req = 3'b011;
    waited = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      waited++;
      if (gnt === 3'b010) break;
    end
    checks++; if (gnt !== 3'b010 || waited > WAIT_BOUND) begin
      errors++; $display("FAIL sat_waiter got gnt=%b after %0d want 010 within %0d", gnt, waited, WAIT_BOUND);
    end
    req = 3'b000;
  endtask

  task automatic test_reset_mid_own();
    do_reset();
    req = 3'b010;
    step();
    for (int i = 0; i < 5; i++) step();
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL midrst_pre got %b want 010", gnt); end
    req = 3'b011;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (gnt !== 3'b000 || disp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_abort got gnt=%b valid=%b busy=%b want 000/0/0", gnt, disp_valid, busy);
    end
    step();
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL midrst_first got %b want 001", gnt); end
    req = 3'b000;
  endtask

  task automatic test_random();
    int wait_c [3];
    int max_wait, onehot_bad, valid_bad;
    do_reset();
    wait_c = '{0, 0, 0};
    max_wait = 0; onehot_bad = 0; valid_bad = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (cyc % 8 == 0) req = 3'($urandom_range(0, 7));
      req_data = {$urandom(), $urandom(), $urandom()};
      step();
      if (gnt !== 3'b000 && gnt !== 3'b001 && gnt !== 3'b010 && gnt !== 3'b100) onehot_bad++;
      if (disp_valid !== (|gnt)) valid_bad++;
      for (int i = 0; i < 3; i++) begin
        if (req[i] && !gnt[i]) wait_c[i]++;
        else wait_c[i] = 0;
        if (wait_c[i] > max_wait) max_wait = wait_c[i];
      end
    end
    checks++; if (onehot_bad != 0) begin errors++; $display("FAIL rand_onehot got %0d bad cycles want 0", onehot_bad); end
    checks++; if (valid_bad != 0) begin errors++; $display("FAIL rand_valid got %0d bad cycles want 0", valid_bad); end
    checks++; if (max_wait > WAIT_BOUND) begin errors++; $display("FAIL rand_wait got %0d want <= %0d", max_wait, WAIT_BOUND); end
    req = 3'b000;
  endtask

  initial begin
    rst = 1'b1;
    req = 3'b000;
    req_data = '0;
    test_reset();
    test_single_grant();
    test_pulse_hold();
    test_round_robin();
    test_starvation();
    test_saturation();
    test_reset_mid_own();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
